// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path.
// Pure declarations; no latency or flow control of its own.
// No handshake; consumed by the converter and the decoder.
package display_pkg;

    typedef enum logic {S_IDLE, S_CONVERT} b2b_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

    typedef logic [3:0] bcd_digit_t;

    // Leading-zero mask: bit i set when digit i and every higher digit are zero.
    // The units digit is always shown, so bit 0 stays low.
    function automatic logic [3:0] calc_blank(input logic [15:0] digits);
        logic [3:0] mask;
        mask    = 4'b0000;
        mask[3] = (digits[15:12] == 4'd0);
        mask[2] = (digits[15:8]  == 8'd0);
        mask[1] = (digits[15:4]  == 12'd0);
        return mask;
    endfunction

endpackage

// File: rtl/bcd_adjust3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
// Combinational, zero latency.
// No handshake; 4-bit wrap, no carry out to the next nibble.
module bcd_adjust3
    import display_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Latency: done BIN_W+1 cycles after the start cycle; 2 cycles for values above 9999.
// Backpressure: start is ignored (not queued) while a conversion or overflow load is pending.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output bcd_digit_t       units,
    output bcd_digit_t       tens,
    output bcd_digit_t       hundreds,
    output bcd_digit_t       thousands,
    output logic             overflow,
    output logic [3:0]       blank
);

    localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

    b2b_state_t       state_q, state_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_shl;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      dig_q, dig_d;
    logic [3:0]       blank_q, blank_d;
    logic             bin_over;
    logic             unused_adj_msb;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
        bcd_adjust3 u_adj (
            .din  (bcd_q[4*i +: 4]),
            .dout (bcd_adj[4*i +: 4])
        );
    end

    // Results never exceed 9999, so the adjusted top bit is always shifted out.
    assign bcd_shl        = {bcd_adj[14:0], shift_q[BIN_W-1]};
    assign unused_adj_msb = bcd_adj[15];
    assign bin_over       = (32'(bin) > BCD_MAX);

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ovf_pend_d = 1'b0;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        dig_d      = dig_q;
        blank_d    = blank_q;
        case (state_q)
            S_IDLE: begin
                if (ovf_pend_q) begin
                    dig_d   = 16'h9999;
                    ovf_d   = 1'b1;
                    blank_d = 4'b0000;
                    done_d  = 1'b1;
                end else if (start) begin
                    if (bin_over) begin
                        ovf_pend_d = 1'b1;
                    end else begin
                        shift_d = bin;
                        bcd_d   = 16'h0000;
                        cnt_d   = 4'd0;
                        state_d = S_CONVERT;
                    end
                end
            end
            S_CONVERT: begin
                bcd_d   = bcd_shl;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    dig_d   = bcd_shl;
                    ovf_d   = 1'b0;
                    blank_d = calc_blank(bcd_shl);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            bcd_q      <= 16'h0000;
            shift_q    <= '0;
            cnt_q      <= 4'd0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dig_q      <= 16'h0000;
            blank_q    <= 4'b1110;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            dig_q      <= dig_d;
            blank_q    <= blank_d;
        end
    end

    assign busy      = (state_q == S_CONVERT);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign blank     = blank_q;
    assign units     = dig_q[3:0];
    assign tens      = dig_q[7:4];
    assign hundreds  = dig_q[11:8];
    assign thousands = dig_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a cycle-level reference model.
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy, done, overflow;
    logic [3:0]       units, tens, hundreds, thousands, blank;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .units     (units),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .overflow  (overflow),
        .blank     (blank)
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: countdown plus decimal arithmetic.
    int m_rem = 0;
    bit m_pend = 0;
    int m_val = 0;
    int m_done = 0, m_busy = 0, m_ovf = 0;
    int m_u = 0, m_t = 0, m_h = 0, m_th = 0, m_blank = 14;

    task automatic publish(input int v, input int o);
        m_u     = v % 10;
        m_t     = (v / 10) % 10;
        m_h     = (v / 100) % 10;
        m_th    = (v / 1000) % 10;
        m_ovf   = o;
        m_blank = ((v < 1000) ? 8 : 0) + ((v < 100) ? 4 : 0) + ((v < 10) ? 2 : 0);
        m_done  = 1;
    endtask

    always @(posedge CLK) begin
        if (RESET) begin
            m_rem = 0; m_pend = 0; m_done = 0; m_ovf = 0;
            m_u = 0; m_t = 0; m_h = 0; m_th = 0; m_blank = 14;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) publish(m_val, 0);
            end else if (m_pend) begin
                m_pend = 0;
                publish(9999, 1);
            end else if (start) begin
                if (int'(bin) > 9999) m_pend = 1;
                else begin
                    m_val = int'(bin);
                    m_rem = BIN_W;
                end
            end
        end
        m_busy = (m_rem > 0) ? 1 : 0;
    end

    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            chk("model_busy", int'(busy), m_busy);
            chk("model_done", int'(done), m_done);
            chk("model_units", int'(units), m_u);
            chk("model_tens", int'(tens), m_t);
            chk("model_hundreds", int'(hundreds), m_h);
            chk("model_thousands", int'(thousands), m_th);
            chk("model_overflow", int'(overflow), m_ovf);
            chk("model_blank", int'(blank), m_blank);
        end
    end

    // Called at posedge+1; returns cycles to done counting the start cycle.
    task automatic do_start(input logic [BIN_W-1:0] v, output int lat, output int bcnt);
        start = 1'b1;
        bin   = v;
        @(posedge CLK); #1;
        start = 1'b0;
        bin   = 14'h3FFF;
        lat   = 1;
        bcnt  = int'(busy);
        while (!done && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
            bcnt += int'(busy);
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic chk_res(input string tag, input int u, input int t, input int h,
                           input int th, input int o, input int blk);
        chk({tag, "_units"}, int'(units), u);
        chk({tag, "_tens"}, int'(tens), t);
        chk({tag, "_hundreds"}, int'(hundreds), h);
        chk({tag, "_thousands"}, int'(thousands), th);
        chk({tag, "_overflow"}, int'(overflow), o);
        chk({tag, "_blank"}, int'(blank), blk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk_res(tag, 0, 0, 0, 0, 0, 14);
    endtask

    initial begin
        int lat, bcnt, ndone;
        RESET = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_vals("reset");
        RESET = 1'b0;
        chk_en = 1;
        @(posedge CLK); #1;

        do_start(14'd1234, lat, bcnt);
        chk("lat_1234", lat, 15);
        chk("busy_cycles_1234", bcnt, 14);
        chk_res("r1234", 4, 3, 2, 1, 0, 0);

        do_start(14'd42, lat, bcnt);
        chk_res("r42", 2, 4, 0, 0, 0, 12);
        do_start(14'd0, lat, bcnt);
        chk("lat_b2b", lat, 15);
        chk_res("r0", 0, 0, 0, 0, 0, 14);
        @(posedge CLK); #1;
        chk("done_one_cycle", int'(done), 0);

        do_start(14'd9999, lat, bcnt);
        chk_res("r9999", 9, 9, 9, 9, 0, 0);
        do_start(14'd10000, lat, bcnt);
        chk("lat_ovf", lat, 2);
        chk_res("r10000", 9, 9, 9, 9, 1, 0);
        do_start(14'd7, lat, bcnt);
        chk_res("r7", 7, 0, 0, 0, 0, 14);

        start = 1'b1; bin = 14'd500;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        start = 1'b1; bin = 14'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) begin
                ndone++;
                chk_res("r500", 0, 0, 5, 0, 0, 8);
            end
        end
        chk("ignored_start_done_count", ndone, 1);

        start = 1'b1; bin = 14'd8765;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk_reset_vals("midreset");
        ndone = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (done) ndone++;
        end
        chk("midreset_no_done", ndone, 0);
        do_start(14'd8765, lat, bcnt);
        chk("lat_8765", lat, 15);
        chk_res("r8765", 5, 6, 7, 8, 0, 0);

        repeat (3) @(posedge CLK);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
